// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD timekeeping core with up/down count and expiry.
// Optional lap register enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter #(
  parameter int MIN_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       tick,
  input  logic       clear,
  input  logic       run_up,
  input  logic       run_down,
  input  logic       write,
  input  logic       read,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       counting,
  output logic       expired,
  output logic       wrap
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_EXP  = 2'd3;

  localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [15:0] live;
  logic [15:0] live_nx;
  logic [15:0] inc_val;
  logic [15:0] dec_val;
  logic [15:0] disp;
  logic        wrap_nx;
  logic        full;
  logic        is_zero;

  assign full = (live[15:12] == MT_MAX) && (live[11:8] == 4'd9)
             && (live[7:4] == 4'd5) && (live[3:0] == 4'd9);
  assign is_zero = (live == 16'h0000);

  // BCD increment with carry rippling through all four digits
  always_comb begin
    inc_val = live;
    if (live[3:0] != 4'd9) begin
      inc_val[3:0] = live[3:0] + 4'd1;
    end else begin
      inc_val[3:0] = 4'd0;
      if (live[7:4] != 4'd5) begin
        inc_val[7:4] = live[7:4] + 4'd1;
      end else begin
        inc_val[7:4] = 4'd0;
        if (live[11:8] != 4'd9) begin
          inc_val[11:8] = live[11:8] + 4'd1;
        end else begin
          inc_val[11:8] = 4'd0;
          if (live[15:12] != MT_MAX)
            inc_val[15:12] = live[15:12] + 4'd1;
          else
            inc_val[15:12] = 4'd0;
        end
      end
    end
  end

  // BCD decrement with borrow; only used when live is nonzero
  always_comb begin
    dec_val = live;
    if (live[3:0] != 4'd0) begin
      dec_val[3:0] = live[3:0] - 4'd1;
    end else begin
      dec_val[3:0] = 4'd9;
      if (live[7:4] != 4'd0) begin
        dec_val[7:4] = live[7:4] - 4'd1;
      end else begin
        dec_val[7:4] = 4'd5;
        if (live[11:8] != 4'd0) begin
          dec_val[11:8] = live[11:8] - 4'd1;
        end else begin
          dec_val[11:8] = 4'd9;
          dec_val[15:12] = live[15:12] - 4'd1;
        end
      end
    end
  end

  // Next-state: clear wins, then per-state run/tick handling
  always_comb begin
    state_nx = state;
    live_nx  = live;
    wrap_nx  = 1'b0;
    if (clear) begin
      state_nx = S_IDLE;
      live_nx  = 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (run_up && !run_down)
            state_nx = S_UP;
          else if (run_down && !run_up)
            state_nx = S_DOWN;
        end
        S_UP: begin
          if (!run_up || run_down) begin
            state_nx = S_IDLE;
          end else if (tick) begin
            live_nx = inc_val;
            wrap_nx = full;
          end
        end
        S_DOWN: begin
          if (!run_down || run_up) begin
            state_nx = S_IDLE;
          end else if (tick) begin
            if (is_zero) begin
              state_nx = S_EXP;
            end else begin
              live_nx = dec_val;
              if (dec_val == 16'h0000)
                state_nx = S_EXP;
            end
          end
        end
        default: begin
          state_nx = S_EXP;
        end
      endcase
    end
  end

  // Live time, state and wrap pulse registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      live  <= 16'h0000;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= live_nx;
      wrap  <= wrap_nx;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [15:0] lap;

  // Lap capture takes the pre-update live value
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      lap <= 16'h0000;
    else if (clear)
      lap <= 16'h0000;
    else if (write)
      lap <= live;
  end

  assign disp = read ? lap : live;
`else
  logic unused_lap;

  assign unused_lap = write ^ read;
  assign disp       = live;
`endif

  assign min_tens = disp[15:12];
  assign min_ones = disp[11:8];
  assign sec_tens = disp[7:4];
  assign sec_ones = disp[3:0];
  assign counting = (state == S_UP) || (state == S_DOWN);
  assign expired  = (state == S_EXP);

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed checks of count up/down, rollover,
// expiry, clear priority and lap capture.
module tb_stopwatch_counter;

  logic       clk;
  logic       nrst;
  logic       tick;
  logic       clear;
  logic       run_up;
  logic       run_down;
  logic       write;
  logic       read;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       counting;
  logic       expired;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  stopwatch_counter #(.MIN_TENS_MAX(5)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .tick     (tick),
    .clear    (clear),
    .run_up   (run_up),
    .run_down (run_down),
    .write    (write),
    .read     (read),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .counting (counting),
    .expired  (expired),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_time(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = {min_tens, min_ones, sec_tens, sec_ones};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {counting, expired, wrap};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cnt/exp/wrap got=%b exp=%b", tag, obs, exp);
    end
  endtask

  initial begin
    nrst = 1'b0; tick = 1'b0; clear = 1'b0;
    run_up = 1'b0; run_down = 1'b0;
    write = 1'b0; read = 1'b0;
    #1;
    chk_time("reset_time", 16'h0000);
    chk_flags("reset_flags", 3'b000);
    step(2);
    nrst = 1'b1;
    step(1);
    chk_flags("idle_after_reset", 3'b000);

    run_up = 1'b1;
    step(1);
    chk_flags("enter_up", 3'b100);
    tick = 1'b1;
    step(60);
    chk_time("up_60", 16'h0100);
    chk_flags("up_60_flags", 3'b100);
    step(540);
    chk_time("up_10_00", 16'h1000);
    step(154);
    chk_time("up_12_34", 16'h1234);
    tick = 1'b0;

    #2;
    nrst = 1'b0;
    #1;
    chk_time("async_reset_time", 16'h0000);
    chk_flags("async_reset_flags", 3'b000);
    run_up = 1'b0;
    step(1);
    nrst = 1'b1;
    step(1);
    chk_flags("idle_after_async", 3'b000);

    run_up = 1'b1;
    step(1);
    tick = 1'b1;
    step(3599);
    chk_time("full_scale", 16'h5959);
    chk_flags("full_scale_flags", 3'b100);
    step(1);
    tick = 1'b0;
    chk_time("rollover", 16'h0000);
    chk_flags("rollover_wrap", 3'b101);
    step(1);
    chk_flags("wrap_one_cycle", 3'b100);

    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);
    tick = 1'b1;
    step(3);
    tick = 1'b0;
    chk_time("up_00_03", 16'h0003);
    run_up = 1'b0;
    run_down = 1'b1;
    step(2);
    chk_flags("enter_down", 3'b100);
    tick = 1'b1;
    step(2);
    chk_time("down_00_01", 16'h0001);
    chk_flags("down_not_yet", 3'b100);
    step(1);
    chk_time("down_00_00", 16'h0000);
    chk_flags("expired_set", 3'b010);
    step(5);
    chk_time("expired_hold", 16'h0000);
    chk_flags("expired_stays", 3'b010);
    tick = 1'b0;
    clear = 1'b1;
    run_down = 1'b0;
    step(1);
    clear = 1'b0;
    chk_flags("clear_expired", 3'b000);

    run_up = 1'b1;
    step(1);
    tick = 1'b1;
    step(7);
    chk_time("up_00_07", 16'h0007);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    tick = 1'b0;
    chk_time("clear_over_tick", 16'h0000);
    chk_flags("clear_idle", 3'b000);
    step(1);
    tick = 1'b1;
    step(5);
    chk_time("up_00_05", 16'h0005);
    run_down = 1'b1;
    step(1);
    chk_time("both_high_hold", 16'h0005);
    chk_flags("both_high_idle", 3'b000);
    step(2);
    chk_time("both_high_idle_hold", 16'h0005);
    tick = 1'b0;

    clear = 1'b1;
    run_down = 1'b0;
    step(1);
    clear = 1'b0;
    step(1);
    tick = 1'b1;
    step(42);
    chk_time("up_00_42", 16'h0042);
    write = 1'b1;
    step(1);
    write = 1'b0;
    tick = 1'b0;
    chk_time("live_00_43", 16'h0043);
    read = 1'b1;
    #1;
`ifdef STOPWATCH_LAP_EN
    chk_time("lap_read", 16'h0042);
    tick = 1'b1;
    step(3);
    tick = 1'b0;
    chk_time("lap_hold", 16'h0042);
    read = 1'b0;
    #1;
    chk_time("live_after_lap", 16'h0046);
`else
    chk_time("read_shows_live", 16'h0043);
    tick = 1'b1;
    step(3);
    tick = 1'b0;
    chk_time("read_live_adv", 16'h0046);
    read = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
